sa_conv_engine: RTL
===================

// Module: sa_conv_engine
// PURPOSE
//  Parametrised successor of the fixed 4x4-image / 3x3-kernel systolic convolution block.
//  Valid-mode 2-D convolution: NxN ifmap, KxK kernel -> MxM result, M=N-K+1.
//  Operands are captured on a start handshake; results are computed by a K-wide row-MAC array.
//  Results are buffered, then streamed row-major on a valid/ready port with saturate/truncate select.
//  Sits between the operand register file and the result/display path.
// PARAMETERS
//  N      4  ifmap side (N>=K)
//  K      3  kernel side (K>=1)
//  DW     8  unsigned operand width (pixel and weight)
//  OUT_W  8  result width on res_data
//  SHIFT  0  LSB index of the acc slice used when sat_en=0
//  Derived: M=N-K+1, ACC_W=2*DW+$clog2(K*K)
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          asynchronous, active-low reset
//  start      in   1          request; accepted only when busy=0
//  abort      in   1          synchronous cancel, active-high
//  sat_en     in   1          1 = clamp to OUT_W; 0 = slice acc[SHIFT+OUT_W-1:SHIFT]
//  ifmap_flat in   N*N*DW     pixel (r,c) at bits [(r*N+c)*DW +: DW]
//  kern_flat  in   K*K*DW     weight (i,j) at bits [(i*K+j)*DW +: DW]
//  busy       out  1          high from the cycle after accept until IDLE
//  res_valid  out  1          result available
//  res_ready  in   1          consumer accepts when valid & ready
//  res_data   out  OUT_W      result value
//  res_last   out  1          high with the final (MxM-th) result
//  done       out  1          one-cycle pulse after the final handshake
// BEHAVIOUR
//  - Reset (reset=0): FSM=IDLE; busy, res_valid, res_last, done, res_data = 0; counters = 0;
//    result buffer contents are don't-care. Reset mid-operation discards everything.
//  - FSM: IDLE -> COMPUTE on start (inputs and sat_en registered on the accept edge).
//    COMPUTE -> OUTPUT after M*M*K cycles. OUTPUT -> IDLE on handshake with res_last=1.
//  - COMPUTE: one output pixel (orow,ocol) per K cycles. Cycle i adds
//    sum_j w(i,j)*x(orow+i, ocol+j) to a zeroed ACC_W accumulator.
//    After i=K-1, the converted value is written to buf[orow*M+ocol]; the accumulator is never wider than ACC_W.
//  - Conversion: sat_en=1 -> min(acc, 2^OUT_W-1); sat_en=0 -> acc[SHIFT+OUT_W-1:SHIFT].
//  - Latency: with the accept edge = edge 0, first res_valid is high after edge M*M*K+1.
//  - OUTPUT: res_valid=1, res_data=buf[idx], res_last=(idx==M*M-1). While ready=0,
//    data, valid and last are held stable. idx advances only on handshake; no bubbles if ready stays high.
//  - done pulses in the cycle after the last handshake, when busy=0 and FSM=IDLE.
//  - start while busy is ignored (not queued). Simultaneous start and final handshake: start is
//    ignored because the FSM is not yet IDLE.
//  - abort (any non-IDLE state): next cycle IDLE, res_valid=0, no done pulse. abort has priority over
//    handshake in the same cycle, and that handshake is not counted. abort in IDLE is a no-op.
//  - ifmap_flat/kern_flat changes after accept have no effect on the current job.
// STRUCTURE
//  - Shared sa_pkg: FSM state encodings (IDLE/COMPUTE/OUTPUT), clog2 function, ACC_W/M macros.
//  - Sub-module sa_row_mac #(K,DW): combinational K-tap dot product of one kernel row against K
//    pixels; the top instantiates one and owns the accumulator, counters and buffer.
//  - Result buffer: M*M x OUT_W register array; counters: orow, ocol, krow, idx.
// TESTING (N=4, K=3, OUT_W=8, SHIFT=0 unless noted)
//  1 All pixels=1, all weights=1, sat_en=1, ready=1 -> four results of 9; first valid at edge 13;
//    last on the 4th; done one cycle later.
//  2 Kernel with centre=1, others=0, ifmap=0..15 row-major -> results 5,6,9,10 in order.
//  3 All operands=255: sat_en=1 -> 255 x4; sat_en=0 -> 0x09 x4 (acc=0x8EE09).
//  4 ready low for 5 cycles mid-stream -> res_data/res_last stable; no result lost or duplicated.
//  5 start pulsed during COMPUTE and OUTPUT -> ignored; sequence identical to test 1.
//  6 abort at edge 6 -> IDLE at edge 7 with no valid/done. reset low during OUTPUT -> all outputs 0
//    at once; a following start yields correct results.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types and sizing helpers for the systolic convolution engine.
package sa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUTPUT  = 2'd2
  } sa_state_e;

  function automatic int unsigned sa_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int unsigned sa_cw(input int unsigned v);
    return (v <= 1) ? 1 : sa_clog2(v);
  endfunction

  function automatic int unsigned sa_out_side(input int unsigned n, input int unsigned k);
    return n - k + 1;
  endfunction

  function automatic int unsigned sa_acc_w(input int unsigned dw, input int unsigned k);
    return 2 * dw + sa_clog2(k * k);
  endfunction

endpackage

// File: rtl/sa_row_mac.sv
// Combinational K-tap dot product of one kernel row against K pixels.
module sa_row_mac
  import sa_pkg::*;
#(
  parameter int unsigned K     = 3,
  parameter int unsigned DW    = 8,
  parameter int unsigned SUM_W = 2 * DW + sa_clog2(K)
) (
  input  logic [K*DW-1:0]  w_row,
  input  logic [K*DW-1:0]  x_row,
  output logic [SUM_W-1:0] sum_c
);

  localparam int unsigned PW = 2 * DW;

  logic [PW-1:0] prod;

  always_comb begin
    sum_c = '0;
    prod  = '0;
    for (int unsigned j = 0; j < K; j++) begin
      prod  = PW'(w_row[j*DW +: DW]) * PW'(x_row[j*DW +: DW]);
      sum_c = sum_c + SUM_W'(prod);
    end
  end

endmodule

// File: rtl/sa_conv_engine.sv
// Valid-mode NxN by KxK convolution: one kernel row per cycle into an accumulator,
// results buffered and then streamed row-major over valid/ready.
module sa_conv_engine
  import sa_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned K     = 3,
  parameter int unsigned DW    = 8,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 sat_en,
  input  logic [N*N*DW-1:0]    ifmap_flat,
  input  logic [K*K*DW-1:0]    kern_flat,
  output logic                 busy,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [OUT_W-1:0]     res_data,
  output logic                 res_last,
  output logic                 done
);

  localparam int unsigned M     = sa_out_side(N, K);
  localparam int unsigned MM    = M * M;
  localparam int unsigned ACC_W = sa_acc_w(DW, K);
  localparam int unsigned RW    = sa_cw(M);
  localparam int unsigned KW    = sa_cw(K);
  localparam int unsigned IW    = sa_cw(MM);
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'({OUT_W{1'b1}});

  sa_state_e             state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  done_q, done_d;
  logic [OUT_W-1:0]      data_q, data_d;
  logic [RW-1:0]         orow_q, orow_d;
  logic [RW-1:0]         ocol_q, ocol_d;
  logic [KW-1:0]         krow_q, krow_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [N*N*DW-1:0]     ifmap_q, ifmap_d;
  logic [K*K*DW-1:0]     kern_q, kern_d;
  logic                  sat_q, sat_d;

  logic [OUT_W-1:0]      buf_q [MM];
  logic                  buf_we;
  logic [OUT_W-1:0]      buf_wdata;

  logic [K*DW-1:0]       w_row;
  logic [K*DW-1:0]       x_row;
  logic [ACC_W-1:0]      row_sum_c;
  logic [ACC_W-1:0]      acc_sum;

  function automatic logic [OUT_W-1:0] to_out(input logic [ACC_W-1:0] a, input logic sat);
    if (sat) return (a > SAT_MAX) ? '1 : a[OUT_W-1:0];
    return a[SHIFT +: OUT_W];
  endfunction

  // Window row (orow+krow, ocol..ocol+K-1) of the captured ifmap.
  always_comb begin
    x_row = '0;
    for (int unsigned j = 0; j < K; j++) begin
      x_row[j*DW +: DW] =
        ifmap_q[((32'(orow_q) + 32'(krow_q)) * N + 32'(ocol_q) + j) * DW +: DW];
    end
  end

  assign w_row = kern_q[32'(krow_q) * K * DW +: K * DW];

  sa_row_mac #(
    .K     (K),
    .DW    (DW),
    .SUM_W (ACC_W)
  ) u_row_mac (
    .w_row (w_row),
    .x_row (x_row),
    .sum_c (row_sum_c)
  );

  assign acc_sum = acc_q + row_sum_c;

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    last_d    = last_q;
    data_d    = data_q;
    done_d    = 1'b0;
    orow_d    = orow_q;
    ocol_d    = ocol_q;
    krow_d    = krow_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    ifmap_d   = ifmap_q;
    kern_d    = kern_q;
    sat_d     = sat_q;
    buf_we    = 1'b0;
    buf_wdata = to_out(acc_sum, sat_q);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_COMPUTE;
          busy_d  = 1'b1;
          ifmap_d = ifmap_flat;
          kern_d  = kern_flat;
          sat_d   = sat_en;
          orow_d  = '0;
          ocol_d  = '0;
          krow_d  = '0;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      ST_COMPUTE: begin
        if (krow_q == KW'(K - 1)) begin
          buf_we = 1'b1;
          acc_d  = '0;
          krow_d = '0;
          idx_d  = idx_q + IW'(1);
          if (ocol_q == RW'(M - 1)) begin
            ocol_d = '0;
            if (orow_q == RW'(M - 1)) begin
              orow_d  = '0;
              idx_d   = '0;
              state_d = ST_OUTPUT;
            end else begin
              orow_d = orow_q + RW'(1);
            end
          end else begin
            ocol_d = ocol_q + RW'(1);
          end
        end else begin
          acc_d  = acc_sum;
          krow_d = krow_q + KW'(1);
        end
      end
      ST_OUTPUT: begin
        // First OUTPUT cycle loads the register stage from the buffer.
        if (!valid_q) begin
          valid_d = 1'b1;
          data_d  = buf_q[idx_q];
          last_d  = (idx_q == IW'(MM - 1));
        end else if (res_ready) begin
          if (last_q) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            data_d  = '0;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            idx_d  = idx_q + IW'(1);
            data_d = buf_q[idx_q + IW'(1)];
            last_d = ((idx_q + IW'(1)) == IW'(MM - 1));
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      data_d  = '0;
      done_d  = 1'b0;
      orow_d  = '0;
      ocol_d  = '0;
      krow_d  = '0;
      idx_d   = '0;
      acc_d   = '0;
      buf_we  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      orow_q  <= '0;
      ocol_q  <= '0;
      krow_q  <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      ifmap_q <= '0;
      kern_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      data_q  <= data_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
      krow_q  <= krow_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      ifmap_q <= ifmap_d;
      kern_q  <= kern_d;
      sat_q   <= sat_d;
    end
  end

  // Result buffer contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[idx_q] <= buf_wdata;
  end

  assign busy      = busy_q;
  assign res_valid = valid_q;
  assign res_last  = last_q;
  assign res_data  = data_q;
  assign done      = done_q;

endmodule
